// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// constant clog2 helper used to size the beat counter and priority pointer.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Ceiling log2, minimum result 1 so single-value ranges still get a bit.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO bus shared between producers, the arbiter and the FIFO
// write pins. "master" is the producer/FIFO side, "slave" is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          fifo_full;
  logic                          fifo_wren;
  logic [DATA_WIDTH-1:0]         fifo_wrdata;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ack, grant, busy, fifo_wren, fifo_wrdata
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ack, grant, busy, fifo_wren, fifo_wrdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit found scanning
// upward from the slot after last_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);
  logic             found;
  logic [PTR_W-1:0] idx;

  // Rotating priority scan; the first hit claims the one-hot winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(last_ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts up to MAX_BURST written beats; IDLE costs one bubble cycle.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic             wrclk,
  input  logic             wrrst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]     last_ptr_q, last_ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 pick_any;
  logic [PTR_W-1:0]     pick_idx;
  logic                 g_valid;
  logic                 accept;
  logic [DATA_WIDTH-1:0] wrdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req      (bus.req_valid),
    .last_ptr (last_ptr_q),
    .winner   (pick_onehot),
    .any_req  (pick_any)
  );

  // Encode the picker's one-hot winner into an index for the data mux.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  // A beat is written only for the granted requester when the FIFO has room.
  always_comb begin
    g_valid = bus.req_valid[gidx_q];
    accept  = (state_q == BURST) && g_valid && !bus.fifo_full;
  end

  // Granted requester's data; zero while idle.
  always_comb begin
    wrdata = '0;
    if (state_q == BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gidx_q == PTR_W'(i)) begin
          wrdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Write strobe and ack are suppressed during reset so no beat is lost.
  assign bus.fifo_wren   = accept && !wrrst;
  assign bus.req_ack     = (accept && !wrrst) ? grant_q : '0;
  assign bus.fifo_wrdata = wrdata;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;

  // Next-state: arbitration in IDLE, burst counting / termination in BURST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    last_ptr_d = last_ptr_q;
    gidx_d     = gidx_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = BURST;
          grant_d    = pick_onehot;
          gidx_d     = pick_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      BURST: begin
        if (!g_valid || (accept && (beat_cnt_q == LAST_BEAT))) begin
          state_d    = IDLE;
          grant_d    = '0;
          busy_d     = 1'b0;
          beat_cnt_d = '0;
          last_ptr_d = gidx_q;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset gives requester 0 first priority.
  always_ff @(posedge wrclk) begin
    if (wrrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      last_ptr_q <= PTR_RST;
      gidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      last_ptr_q <= last_ptr_d;
      gidx_q     <= gidx_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus a random
// phase, checked against a cycle-level behavioural model of the arbiter.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(2))  bus2 ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .wrclk (clk),
    .wrrst (rst),
    .bus   (bus)
  );

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(2), .MAX_BURST(1)) dut2 (
    .wrclk (clk),
    .wrrst (rst2),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NR-1:0] grant;
    logic          busy;
    logic          wr;
  } cyc_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NR-1:0] ack;
  } wr_t;

  cyc_t          exp_cyc[$];
  wr_t           exp_wr[$];
  logic [DW-1:0] src_q[NR][$];
  logic [NR-1:0] pause_mask = '0;
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_last  = NR - 1;
  int            wr_cnt  = 0;
  int            wr_per[NR];
  bit            mon_en  = 0;
  bit            done2   = 0;

  // Reference: round-robin choice, first requester after the last winner.
  function automatic int rr_model(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[2'((last + k) % NR)]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // One clock of stimulus: present each requester's head beat, predict the
  // cycle's outcome, retire the beat if it is written, advance the model.
  task automatic drive_cycle(input bit r, input bit full);
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    cyc_t             c;
    wr_t              w;
    bit               wr;
    v = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        v[i] = ~pause_mask[i];
        d[i*DW +: DW] = src_q[i][0];
      end
    end
    rst           = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.fifo_full = full;
    wr = !r && (m_owner >= 0) && v[2'(m_owner)] && !full;
    c.grant = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
    c.busy  = (m_owner >= 0);
    c.wr    = wr;
    exp_cyc.push_back(c);
    if (wr) begin
      w.data = src_q[2'(m_owner)][0];
      w.ack  = NR'(1) << m_owner;
      exp_wr.push_back(w);
      void'(src_q[2'(m_owner)].pop_front());
    end
    if (r) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = NR - 1;
    end else if (m_owner < 0) begin
      m_owner = rr_model(v, m_last);
      m_beats = 0;
    end else if (!v[2'(m_owner)]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (wr) begin
      m_beats++;
      if (m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    pause_mask = '0;
  endtask

  // Monitor: every cycle compare grant/busy/wren; on a write compare data/ack.
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_cyc.size() == 0) begin
          chk("cycle_queue", 32'd0, 32'd1);
        end else begin
          c = exp_cyc.pop_front();
          chk("grant", 32'(bus.grant), 32'(c.grant));
          chk("busy", 32'(bus.busy), 32'(c.busy));
          chk("wren", 32'(bus.fifo_wren), 32'(c.wr));
          if (bus.fifo_wren) begin
            wr_cnt++;
            for (int i = 0; i < NR; i++) if (bus.req_ack[i]) wr_per[i]++;
          end
          if (bus.fifo_wren || c.wr) begin
            if (exp_wr.size() == 0) begin
              chk("write_queue", 32'd0, 32'd1);
            end else begin
              w = exp_wr.pop_front();
              chk("wrdata", 32'(bus.fifo_wrdata), 32'(w.data));
              chk("req_ack", 32'(bus.req_ack), 32'(w.ack));
            end
          end else begin
            chk("req_ack_idle", 32'(bus.req_ack), 32'd0);
          end
        end
      end
    end
  end

  // Second build: MAX_BURST=1, two requesters always requesting.
  initial begin
    logic [1:0] eg;
    bus2.req_valid = '0;
    bus2.req_data  = {8'hC3, 8'h3C};
    bus2.fifo_full = 1'b0;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    bus2.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      eg = ((k % 4) == 1) ? 2'b01 : (((k % 4) == 3) ? 2'b10 : 2'b00);
      chk("mb1_grant", 32'(bus2.grant), 32'(eg));
      chk("mb1_wren", 32'(bus2.fifo_wren), 32'(k % 2));
      chk("mb1_ack", 32'(bus2.req_ack), 32'(eg));
      if ((k % 2) == 1) begin
        chk("mb1_data", 32'(bus2.fifo_wrdata), ((k % 4) == 1) ? 32'h3C : 32'hC3);
      end
    end
    done2 = 1;
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int            base;
    int            base_p[NR];
    logic [DW-1:0] t1[5];
    bit            r;
    bit            f;
    t1 = '{8'hA8, 8'h08, 8'h68, 8'h54, 8'h11};
    for (int i = 0; i < NR; i++) wr_per[i] = 0;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1;

    // Single requester, 5 beats: 4-beat burst, bubble, 1-beat re-grant.
    drive_cycle(1, 0);
    for (int i = 0; i < 5; i++) src_q[0].push_back(t1[i]);
    base = wr_cnt;
    repeat (12) drive_cycle(0, 0);
    chk("t1_writes", 32'(wr_cnt - base), 32'd5);

    // All four requesting: 16 writes in 20 cycles, rotating grants.
    clear_src();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 20; j++) src_q[i].push_back(8'($urandom_range(0, 255)));
    drive_cycle(1, 0);
    base = wr_cnt;
    repeat (20) drive_cycle(0, 0);
    chk("t2_writes_20cyc", 32'(wr_cnt - base), 32'd16);

    // Requester 2 with a 5-cycle full stall after its first beat.
    clear_src();
    drive_cycle(1, 0);
    for (int j = 0; j < 4; j++) src_q[2].push_back(8'($urandom_range(0, 255)));
    base = wr_cnt;
    repeat (2) drive_cycle(0, 0);
    repeat (5) drive_cycle(0, 1);
    repeat (5) drive_cycle(0, 0);
    chk("t3_writes", 32'(wr_cnt - base), 32'd4);

    // Requester 1 drops after 2 beats while requester 3 waits.
    clear_src();
    drive_cycle(1, 0);
    for (int j = 0; j < 2; j++) src_q[1].push_back(8'($urandom_range(0, 255)));
    for (int j = 0; j < 3; j++) src_q[3].push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < NR; i++) base_p[i] = wr_per[i];
    repeat (10) drive_cycle(0, 0);
    chk("t4_req1_credit", 32'(wr_per[1] - base_p[1]), 32'd2);
    chk("t4_req3_credit", 32'(wr_per[3] - base_p[3]), 32'd3);

    // Reset during requester 3's third beat; requester 0 then wins.
    clear_src();
    drive_cycle(1, 0);
    for (int j = 0; j < 6; j++) src_q[3].push_back(8'($urandom_range(0, 255)));
    repeat (3) drive_cycle(0, 0);
    for (int j = 0; j < 2; j++) src_q[0].push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < NR; i++) base_p[i] = wr_per[i];
    drive_cycle(1, 0);
    chk("t5_no_write_in_reset", 32'(wr_per[3] - base_p[3]), 32'd0);
    repeat (4) drive_cycle(0, 0);
    chk("t5_req0_after_reset", 32'(wr_per[0] - base_p[0]), 32'd2);
    repeat (8) drive_cycle(0, 0);

    // Random traffic, drops, full stalls and occasional resets.
    clear_src();
    drive_cycle(1, 0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() == 0 && ($urandom % 4) == 0) begin
          for (int j = 0; j < int'($urandom_range(1, 7)); j++)
            src_q[i].push_back(8'($urandom_range(0, 255)));
        end
        pause_mask[i] = (($urandom % 20) == 0);
      end
      f = (($urandom % 5) == 0);
      r = (($urandom % 300) == 0);
      drive_cycle(r, f);
    end

    mon_en = 0;
    chk("leftover_writes", 32'(exp_wr.size()), 32'd0);
    chk("leftover_cycles", 32'(exp_cyc.size()), 32'd0);
    chk("mb1_done", 32'(done2), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
